// File: rtl/lsu_pkg.sv
// Shared types and helpers for the byte-serial load/store unit.
// Size encodings, FSM state encoding and the latched request bundle.
package lsu_pkg;

  localparam logic [2:0] SZ_BYTE = 3'b001;
  localparam logic [2:0] SZ_HALF = 3'b010;
  localparam logic [2:0] SZ_WORD = 3'b100;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic        we;
    logic [2:0]  size;
    logic        uns;
    logic [31:0] wdata;
  } lsu_req_t;

  // Byte count for a size code; 0 marks an illegal size.
  function automatic logic [2:0] size_to_bytes(
    input logic [2:0] size
  );
    logic [2:0] n;
    n = 3'd0;
    unique case (1'b1)
      (size == SZ_BYTE): n = 3'd1;
      (size == SZ_HALF): n = 3'd2;
      (size == SZ_WORD): n = 3'd4;
      default:           n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic logic misaligned(
    input logic [2:0] size,
    input logic [1:0] lo
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      (size == SZ_HALF): m = lo[0];
      (size == SZ_WORD): m = |lo;
      default:           m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of assembled load data.
// Word loads pass through unchanged.
module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  size,
  input  logic        uns,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    unique case (1'b1)
      (size == SZ_BYTE):
        ext = {uns ? 24'h0 : {24{raw[7]}}, raw[7:0]};
      (size == SZ_HALF):
        ext = {uns ? 16'h0 : {16{raw[15]}}, raw[15:0]};
      default:
        ext = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial data-memory initiator for the MEM stage.
// Define MISALIGN_TRAP_EN to reject misaligned half/word accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  logic [1:0]        state;
  lsu_req_t          req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        cnt;
  logic [2:0]        n_q;
  logic [31:0]       asm_q;
  logic              err_q;

  logic              accept;
  logic [2:0]        req_n;
  logic              trap;
  logic              bad;
  logic              in_xfer;
  logic              in_resp;
  logic              last;
  logic [31:0]       ext;

  assign accept = req_valid & req_ready;
  assign req_n  = size_to_bytes(req_size);

`ifdef MISALIGN_TRAP_EN
  assign trap = misaligned(req_size, req_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign bad     = (req_n == 3'd0) | trap;
  assign in_xfer = (state == ST_XFER);
  assign in_resp = (state == ST_RESP);
  assign last    = ({1'b0, cnt} == (n_q - 3'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      req_q  <= '0;
      addr_q <= '0;
      cnt    <= '0;
      n_q    <= '0;
      asm_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (accept) begin
            req_q.we    <= req_we;
            req_q.size  <= req_size;
            req_q.uns   <= req_unsigned;
            req_q.wdata <= req_wdata;
            addr_q      <= req_addr;
            cnt         <= 2'd0;
            n_q         <= req_n;
            asm_q       <= '0;
            err_q       <= bad;
            state       <= bad ? ST_RESP : ST_XFER;
          end
        end
        (state == ST_XFER): begin
          if (!req_q.we)
            asm_q[{cnt, 3'b000} +: 8] <= mem_rdata;
          if (last)
            state <= ST_RESP;
          else
            cnt <= cnt + 2'd1;
        end
        (state == ST_RESP): begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  load_extend u_ext (
    .size (req_q.size),
    .uns  (req_q.uns),
    .raw  (asm_q),
    .ext  (ext)
  );

  // Address wraps naturally through the ADDR_W-bit adder.
  always_comb begin
    req_ready = (state == ST_IDLE);
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    if (in_xfer) begin
      mem_addr = addr_q + ADDR_W'(cnt);
      mem_re   = ~req_q.we;
      mem_we   = req_q.we;
      if (req_q.we)
        mem_wdata = req_q.wdata[{cnt, 3'b000} +: 8];
    end
  end

  always_comb begin
    rsp_valid = in_resp;
    rsp_err   = in_resp & err_q;
    rsp_rdata = 32'h0;
    if (in_resp && !err_q && !req_q.we)
      rsp_rdata = ext;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table,
// reset-abort sequence and randomized traffic vs a byte-array model.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  tb_mem  [256];
  logic [7:0]  ref_mem [256];

  int passed = 0;
  int total  = 0;

  logic [31:0] tr_addr[$];
  logic [7:0]  tr_data[$];
  int          tr_stb;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_addr     (mem_addr),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem_re ? tb_mem[mem_addr[7:0]] : 8'h00;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Issue one request from an idle unit and observe it to completion.
  task automatic run_req(input logic we, input logic [2:0] size,
                         input logic uns, input logic [31:0] addr,
                         input logic [31:0] wdata, output int cyc,
                         output logic [31:0] rd, output logic er);
    logic       pend;
    logic [7:0] pa;
    logic [7:0] pd;
    pend = 1'b0;
    pa = 8'h00;
    pd = 8'h00;
    cyc = 0;
    rd = 32'hx;
    er = 1'bx;
    tr_addr.delete();
    tr_data.delete();
    tr_stb = 0;
    req_we = we;
    req_size = size;
    req_unsigned = uns;
    req_addr = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    check("ready_before_req", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (pend) tb_mem[pa] = pd;
      pend = 1'b0;
      if (k == 1) check("busy_not_ready", req_ready, 1'b0);
      if (mem_we || mem_re) begin
        tr_stb++;
        tr_addr.push_back(mem_addr);
      end
      if (mem_we) begin
        tr_data.push_back(mem_wdata);
        pend = 1'b1;
        pa = mem_addr[7:0];
        pd = mem_wdata;
      end
      if (rsp_valid) begin
        cyc = k;
        rd = rsp_rdata;
        er = rsp_err;
        break;
      end
      @(posedge clk); #1;
    end
    if (cyc != 0) begin
      @(posedge clk); #1;
      check("rsp_one_cycle", rsp_valid, 1'b0);
      check("ready_after_rsp", req_ready, 1'b1);
    end
  endtask

  // Reference: memory as a plain byte array, values by arithmetic.
  task automatic model(input logic we, input logic [2:0] size,
                       input logic uns, input logic [31:0] addr,
                       input logic [31:0] wdata, output int n,
                       output logic err, output logic [31:0] rd,
                       output int cyc);
    longint unsigned raw;
    longint          val;
    n = (size == 3'd1) ? 1 : (size == 3'd2) ? 2 :
        (size == 3'd4) ? 4 : 0;
    err = (n == 0);
`ifdef MISALIGN_TRAP_EN
    if (n != 0 && (addr % n) != 0) err = 1'b1;
`endif
    rd = 32'h0;
    if (err) begin
      n = 0;
      cyc = 1;
      return;
    end
    cyc = n + 1;
    raw = 0;
    for (int i = 0; i < n; i++) begin
      logic [7:0] ix;
      ix = 8'(addr + i);
      if (we) ref_mem[ix] = 8'((wdata >> (8 * i)) & 32'hFF);
      else raw = raw + (longint'(ref_mem[ix]) << (8 * i));
    end
    if (!we) begin
      val = longint'(raw);
      if (!uns && raw >= (64'd1 << (8 * n - 1)))
        val = val - longint'(64'd1 << (8 * n));
      rd = 32'(val);
    end
  endtask

  function automatic logic trace_ok(input logic we,
                                    input logic [31:0] addr,
                                    input logic [31:0] wdata,
                                    input int n);
    if (tr_addr.size() != n) return 1'b0;
    if (we && tr_data.size() != n) return 1'b0;
    for (int i = 0; i < n; i++) begin
      if (tr_addr[i] != addr + 32'(i)) return 1'b0;
      if (we && tr_data[i] != wdata[8 * i +: 8]) return 1'b0;
    end
    return 1'b1;
  endfunction

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pre;
    logic [31:0] rd;
    logic        err;
    int          cyc;
    int          nstb;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int          cyc;
    logic [31:0] rd;
    logic        er;
    int          en;
    logic        eerr;
    logic [31:0] erd;
    int          ecyc;
    int          seen;

    for (int i = 0; i < 256; i++) tb_mem[i] = 8'h00;
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 3'b000;
    req_unsigned = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", req_ready, 1'b1);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rdata", rsp_rdata, 32'h0);
    check("reset_err", rsp_err, 1'b0);
    check("reset_strobes", {mem_re, mem_we}, 2'b00);
    check("reset_addr", mem_addr, 32'h0);
    check("reset_wdata", mem_wdata, 8'h00);
    rst = 1'b0;
    @(posedge clk); #1;

    vecs[0] = '{1'b1, 3'b100, 1'b0, 32'h10, 32'hDEADBEEF,
                32'h0, 32'h0, 1'b0, 5, 4};
    vecs[1] = '{1'b0, 3'b001, 1'b0, 32'h20, 32'h0,
                32'h80, 32'hFFFFFF80, 1'b0, 2, 1};
    vecs[2] = '{1'b0, 3'b001, 1'b1, 32'h20, 32'h0,
                32'h80, 32'h00000080, 1'b0, 2, 1};
    vecs[3] = '{1'b0, 3'b010, 1'b0, 32'h02, 32'h0,
                32'h9234, 32'hFFFF9234, 1'b0, 3, 2};
    vecs[4] = '{1'b0, 3'b010, 1'b1, 32'h02, 32'h0,
                32'h9234, 32'h00009234, 1'b0, 3, 2};
`ifdef MISALIGN_TRAP_EN
    vecs[5] = '{1'b0, 3'b100, 1'b0, 32'h01, 32'h0,
                32'h44332211, 32'h0, 1'b1, 1, 0};
`else
    vecs[5] = '{1'b0, 3'b100, 1'b0, 32'h01, 32'h0,
                32'h44332211, 32'h44332211, 1'b0, 5, 4};
`endif
    vecs[6] = '{1'b1, 3'b100, 1'b0, 32'hFFFFFFFE, 32'h11223344,
                32'h0, 32'h0, 1'b0, 5, 4};
    vecs[7] = '{1'b0, 3'b011, 1'b0, 32'h30, 32'h0,
                32'h0, 32'h0, 1'b1, 1, 0};
    vecs[8] = '{1'b1, 3'b001, 1'b0, 32'h33, 32'h000000A5,
                32'h0, 32'h0, 1'b0, 2, 1};

    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < 4; i++)
        tb_mem[8'(vecs[v].addr + 32'(i))] = vecs[v].pre[8 * i +: 8];
      run_req(vecs[v].we, vecs[v].size, vecs[v].uns, vecs[v].addr,
              vecs[v].wdata, cyc, rd, er);
      check($sformatf("vec%0d_cycle", v), cyc, vecs[v].cyc);
      check($sformatf("vec%0d_rdata", v), rd, vecs[v].rd);
      check($sformatf("vec%0d_err", v), er, vecs[v].err);
      check($sformatf("vec%0d_strobes", v), tr_stb, vecs[v].nstb);
      check($sformatf("vec%0d_trace", v),
            trace_ok(vecs[v].we, vecs[v].addr, vecs[v].wdata,
                     vecs[v].nstb), 1'b1);
    end
    check("store_mem_10", {tb_mem[8'h13], tb_mem[8'h12],
                           tb_mem[8'h11], tb_mem[8'h10]}, 32'hDEADBEEF);
    check("store_wrap_mem", {tb_mem[8'h01], tb_mem[8'h00],
                             tb_mem[8'hFF], tb_mem[8'hFE]}, 32'h11223344);

    // Reset in the third transfer cycle of a word store.
    for (int i = 0; i < 4; i++) tb_mem[8'h40 + i] = 8'h00;
    req_we = 1'b1;
    req_size = 3'b100;
    req_unsigned = 1'b0;
    req_addr = 32'h40;
    req_wdata = 32'hA1B2C3D4;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_c1_we", mem_we, 1'b1);
    @(posedge clk); #1;
    tb_mem[8'h40] = 8'hD4;
    @(posedge clk); #1;
    tb_mem[8'h41] = 8'hC3;
    check("abort_c3_we", mem_we, 1'b1);
    check("abort_c3_addr", mem_addr, 32'h42);
    #2;
    rst = 1'b1;
    #1;
    check("abort_we_drop", mem_we, 1'b0);
    check("abort_no_rsp", rsp_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid || mem_we || mem_re) seen++;
      @(posedge clk); #1;
    end
    check("abort_quiet_after", seen, 0);
    check("abort_ready", req_ready, 1'b1);
    check("abort_bytes01", {tb_mem[8'h41], tb_mem[8'h40]}, 16'hC3D4);

    // Randomized traffic against the byte-array model.
    for (int i = 0; i < 256; i++) begin
      tb_mem[i] = 8'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    for (int t = 0; t < 150; t++) begin
      logic        we;
      logic [2:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        mem_ok;
      int          pick;
      pick = $urandom_range(0, 9);
      if (pick == 0) begin
        size = 3'($urandom_range(0, 7));
        if (size == 3'd1 || size == 3'd2 || size == 3'd4) size = 3'd7;
      end else if (pick < 4) size = 3'b001;
      else if (pick < 7) size = 3'b010;
      else size = 3'b100;
      we = 1'($urandom);
      uns = 1'($urandom);
      addr = ($urandom_range(0, 3) == 0) ? $urandom
                                         : 32'($urandom_range(0, 255));
      wdata = $urandom;
      model(we, size, uns, addr, wdata, en, eerr, erd, ecyc);
      run_req(we, size, uns, addr, wdata, cyc, rd, er);
      check($sformatf("rnd%0d_cycle", t), cyc, ecyc);
      check($sformatf("rnd%0d_rdata", t), rd, erd);
      check($sformatf("rnd%0d_err", t), er, eerr);
      check($sformatf("rnd%0d_strobes", t), tr_stb, en);
      check($sformatf("rnd%0d_trace", t),
            trace_ok(we, addr, wdata, en), 1'b1);
      mem_ok = 1'b1;
      for (int i = 0; i < 4; i++)
        if (tb_mem[8'(addr + 32'(i))] != ref_mem[8'(addr + 32'(i))])
          mem_ok = 1'b0;
      check($sformatf("rnd%0d_mem", t), mem_ok, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
